// File: rtl/sram_pkg.sv
// Shared types for the SRAM write path: bus widths, controller states, queued write entry.
package sram_pkg;
    localparam int SRAM_ADDR_W = 20;
    localparam int SRAM_DATA_W = 16;

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} sram_wr_state_t;

    typedef struct packed {
        logic [SRAM_ADDR_W-1:0] addr;
        logic [SRAM_DATA_W-1:0] data;
        logic [1:0]             be;
    } sram_wr_entry_t;
endpackage

// File: rtl/sram_wr_fifo.sv
// Synchronous write-entry queue; head is visible combinationally, pop takes effect at the edge.
// Push is ignored when full and pop is ignored when empty; push and pop together keep count steady.
module sram_wr_fifo
    import sram_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           push,
    input  sram_wr_entry_t push_entry,
    input  logic           pop,
    output sram_wr_entry_t head,
    output logic [PTR_W:0] count
);
    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    sram_wr_entry_t   mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && (count != FULL);
    assign pop_ok  = pop && (count != '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Power-of-2 depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/sram_write_controller.sv
// Queues SRAM write requests and plays each out as setup / WE-pulse / hold, parking in read mode between.
// Latency push->SETUP is 2 cycles; Wr_ready drops while the queue is full.
module sram_write_controller
    import sram_pkg::*;
#(
    parameter int ADDR_W       = 20,
    parameter int DATA_W       = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int SETUP_CYCLES = 1,
    parameter int WE_CYCLES    = 2,
    parameter int HOLD_CYCLES  = 1,
    localparam int FC_W        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Wr_valid,
    output logic              Wr_ready,
    input  logic [ADDR_W-1:0] Wr_addr,
    input  logic [DATA_W-1:0] Wr_data,
    input  logic [1:0]        Wr_be,
    input  logic              Hold,
    input  logic [ADDR_W-1:0] Rd_addr,
    output logic [ADDR_W-1:0] ADDR,
    output logic              CE,
    output logic              UB,
    output logic              LB,
    output logic              OE,
    output logic              WE,
    output logic [DATA_W-1:0] Data_to_SRAM,
    output logic              Data_oe,
    output logic              Busy,
    output logic [FC_W-1:0]   Fifo_count
);
    localparam int MAX_A   = (SETUP_CYCLES > WE_CYCLES) ? SETUP_CYCLES : WE_CYCLES;
    localparam int MAX_CYC = (MAX_A > HOLD_CYCLES) ? MAX_A : HOLD_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [FC_W-1:0] FULL = FC_W'(FIFO_DEPTH);

    sram_wr_state_t state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    sram_wr_entry_t   latch, latch_nxt;
    sram_wr_entry_t   head;
    sram_wr_entry_t   push_entry;
    logic             pop;
    logic             push;

    assign push_entry = '{addr: SRAM_ADDR_W'(Wr_addr), data: SRAM_DATA_W'(Wr_data), be: Wr_be};
    assign Wr_ready   = Reset_n && (Fifo_count != FULL);
    assign push       = Wr_valid && Wr_ready;
    assign Busy       = Reset_n && ((state != IDLE) || (Fifo_count != '0));

    sram_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (Clk),
        .rst_n      (Reset_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (Fifo_count)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            latch <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            latch <= latch_nxt;
        end
    end

    // Entries with no byte enables are consumed in IDLE without touching the bus.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        latch_nxt = latch;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if ((Fifo_count != '0) && !Hold) begin
                    pop       = 1'b1;
                    latch_nxt = head;
                    if (head.be != 2'b00) begin
                        state_nxt = SETUP;
                        cnt_nxt   = CNT_W'(SETUP_CYCLES - 1);
                    end
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_nxt = PULSE;
                    cnt_nxt   = CNT_W'(WE_CYCLES - 1);
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            PULSE: begin
                if (cnt == '0) begin
                    state_nxt = HOLD;
                    cnt_nxt   = CNT_W'(HOLD_CYCLES - 1);
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Defaults are the reset-safe bus: everything deasserted, tristate off.
    always_comb begin
        CE           = 1'b1;
        OE           = 1'b1;
        WE           = 1'b1;
        UB           = 1'b1;
        LB           = 1'b1;
        Data_oe      = 1'b0;
        Data_to_SRAM = '0;
        ADDR         = '0;
        if (Reset_n) begin
            CE = 1'b0;
            if (state == IDLE) begin
                OE   = 1'b0;
                UB   = 1'b0;
                LB   = 1'b0;
                ADDR = Rd_addr;
            end else begin
                ADDR         = ADDR_W'(latch.addr);
                Data_to_SRAM = DATA_W'(latch.data);
                Data_oe      = 1'b1;
                UB           = ~latch.be[1];
                LB           = ~latch.be[0];
                WE           = (state != PULSE);
            end
        end
    end
endmodule

// File: doc/sram_write_controller.md
Name: sram_write_controller

Overview:
- Write-side controller for the 1M x 16 async SRAM that holds sprite and frame data. The drawing engine's load path reads this SRAM.
- Accepts buffered write requests (address, data, byte enables) over a valid/ready handshake and queues them in a small FIFO.
- Sequences each request as a setup / WE-pulse / hold bus cycle on the active-low SRAM controls.
- Between writes it parks the bus in read mode (CE=0, OE=0, WE=1), so the read path keeps working.

Parameters:
- ADDR_W, 20: SRAM address width.
- DATA_W, 16: SRAM data width.
- FIFO_DEPTH, 4: write queue entries. Must be a power of 2 and at least 2.
- SETUP_CYCLES, 1: cycles that address, data and byte enables are stable before WE falls. Must be at least 1.
- WE_CYCLES, 2: cycles WE is held low. Must be at least 1.
- HOLD_CYCLES, 1: cycles that data and address are held after WE rises. Must be at least 1.

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous, active-low reset.
- Wr_valid  in  1  write request valid.
- Wr_ready  out  1  queue can accept a request.
- Wr_addr  in  ADDR_W  write address.
- Wr_data  in  DATA_W  write data.
- Wr_be  in  2  byte enables: [1]=upper byte, [0]=lower byte, active-high.
- Hold  in  1  when high, no new write starts. A write already in progress completes.
- Rd_addr  in  ADDR_W  address driven onto ADDR while IDLE (read path).
- ADDR  out  ADDR_W  SRAM address.
- CE, UB, LB, OE, WE  out  1 each  SRAM controls, all active-low.
- Data_to_SRAM  out  DATA_W  write data for the top-level tristate.
- Data_oe  out  1  enables the data tristate toward the SRAM.
- Busy  out  1  high when state is not IDLE or the FIFO is not empty.
- Fifo_count  out  $clog2(FIFO_DEPTH)+1  current queue occupancy.

Behaviour:
Reset:
- Clk is the single clock. Reset_n is asynchronous and active-low.
- While Reset_n=0: FIFO empty, state IDLE, counters 0, latched entry 0.
- While Reset_n=0, outputs are forced combinationally to CE=1, OE=1, WE=1, UB=1, LB=1, Data_oe=0, Data_to_SRAM=0, ADDR=0, Wr_ready=0, Busy=0.
- Reset asserted mid-write: WE rises immediately and Data_oe drops. The target word's contents are undefined. All queued entries are lost.

FIFO:
- Wr_ready = (count < FIFO_DEPTH), taken from the registered count. There is no pass-through when full.
- A push occurs on a Clk edge with Wr_valid and Wr_ready both high.
- A push and a pop on the same edge leave count unchanged. Pointers wrap modulo FIFO_DEPTH.

FSM states: IDLE, SETUP, PULSE, HOLD.
- IDLE: CE=0, OE=0, WE=1, UB=0, LB=0, ADDR=Rd_addr, Data_oe=0.
  - If count>0 and Hold=0: pop the head into the latch.
  - If the head's be!=2'b00: go to SETUP and load counter with SETUP_CYCLES-1.
  - If the head's be==2'b00: drop the entry (no bus cycle) and stay in IDLE.
- SETUP: CE=0, OE=1, WE=1, ADDR=latched addr, Data_to_SRAM=latched data, Data_oe=1, UB=~be[1], LB=~be[0].
  - When counter reaches 0: go to PULSE and load WE_CYCLES-1.
- PULSE: same outputs as SETUP, except WE=0.
  - When counter reaches 0: go to HOLD and load HOLD_CYCLES-1.
- HOLD: same outputs as SETUP (WE=1).
  - When counter reaches 0: go to IDLE unconditionally. This guarantees at least one read-mode cycle between writes.

Output and timing rules:
- Outside IDLE, outputs depend only on state and the latched entry. Rd_addr reaches ADDR only in IDLE.
- Latency: a push into an empty FIFO on edge t gives IDLE with pop in cycle t+1, SETUP starting in cycle t+2, and WE low after SETUP_CYCLES more cycles.
- Throughput: one write per SETUP_CYCLES+WE_CYCLES+HOLD_CYCLES+1 cycles, which is 5 with defaults.
- Hold: sampled only in IDLE. Raising Hold during SETUP, PULSE or HOLD does not truncate the write. Pushes are still accepted while Hold=1.

Decomposition:
- sram_pkg holds:
  - constants SRAM_ADDR_W=20 and SRAM_DATA_W=16;
  - enum sram_wr_state_t {IDLE, SETUP, PULSE, HOLD};
  - struct sram_wr_entry_t {addr, data, be[1:0]}.
- Sub-module sram_wr_fifo: a synchronous FIFO of sram_wr_entry_t with push/pop/count and the same async active-low reset.
- The FSM, cycle counter and output decode stay in the top module.

Test Plan:
1. Reset: hold Reset_n=0 for 3 cycles, with Wr_valid=1 for part of it -> CE=OE=WE=1, Data_oe=0, Wr_ready=0, Busy=0. After release: Wr_ready=1, Fifo_count=0, and ADDR follows Rd_addr=20'h00ABC.
2. Single write: push addr=20'h01234, data=16'hBEEF, be=2'b11 -> SETUP begins 2 cycles after the push edge. WE is low exactly 2 cycles with ADDR=20'h01234, Data_to_SRAM=16'hBEEF, UB=LB=0. Data_oe spans 4 cycles, then IDLE with OE=0.
3. Byte writes and drop: push be=2'b10 then be=2'b00 then be=2'b01 -> first write has UB=0, LB=1; second entry causes no WE pulse; third has UB=1, LB=0. Exactly 2 WE pulses total.
4. Full/backpressure: push 5 back-to-back with Hold=1 -> Wr_ready falls after 4 accepted and Fifo_count=4. Release Hold -> 4 writes spaced 5 cycles apart in FIFO order, with no entry lost or duplicated.
5. Hold mid-write: assert Hold during PULSE -> the current write completes (WE low for 2 cycles). The next queued entry does not start until Hold=0, and Busy stays 1.
6. Reset mid-write: drop Reset_n during PULSE with 2 entries queued -> WE=1 and Data_oe=0 in the same cycle. After release Fifo_count=0 and no further WE pulses occur.
